// File: rtl/spike_readout_pkg.sv
// Shared types and helpers for the spike readout path: the window FSM
// state encoding and the index-width calculation used by the argmax block.
package spike_readout_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    INTEGRATE = 3'd2,
    SETTLE    = 3'd3,
    SCAN      = 3'd4,
    DONE      = 3'd5
  } state_e;

  // Bits needed to index n classes (at least one bit).
  function automatic int calc_idx_width(input int n);
    if (n <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/spike_window_argmax_argmax_step.sv
// One step of the serial argmax: folds a candidate class into the running
// maximum, keeping the lowest index on ties and flagging equal maxima.
module argmax_step #(
  parameter int size_code = 8,
  parameter int idx_width = 4
) (
  input  logic                 first,
  input  logic [size_code-1:0] cand_val,
  input  logic [idx_width-1:0] cand_idx,
  input  logic [size_code-1:0] max_val,
  input  logic [idx_width-1:0] max_idx,
  input  logic                 max_tie,
  output logic [size_code-1:0] new_val,
  output logic [idx_width-1:0] new_idx,
  output logic                 new_tie
);

  // Strictly-greater replaces the max; equality only raises the tie flag.
  always_comb begin
    new_val = max_val;
    new_idx = max_idx;
    new_tie = max_tie;
    if (first) begin
      new_val = cand_val;
      new_idx = cand_idx;
      new_tie = 1'b0;
    end else if (cand_val > max_val) begin
      new_val = cand_val;
      new_idx = cand_idx;
      new_tie = 1'b0;
    end else if (cand_val == max_val) begin
      new_tie = 1'b1;
    end else begin
      new_tie = max_tie;
    end
  end

endmodule

// File: rtl/spike_window_argmax.sv
// Classification window sequencer: clears and gates the spike counter bank,
// snapshots the settled counts and serially scans them for the winning class.
module spike_window_argmax
  import spike_readout_pkg::*;
#(
  parameter int size_code     = 8,
  parameter int num_counters  = 10,
  parameter int idx_width     = calc_idx_width(num_counters),
  parameter int window_width  = 16,
  parameter int settle_cycles = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [window_width-1:0]           window_len,
  input  logic [num_counters*size_code-1:0] counts,
  output logic                              cnt_clear_n,
  output logic                              cnt_enable,
  output logic                              busy,
  output logic                              done,
  output logic [idx_width-1:0]              winner_idx,
  output logic [size_code-1:0]              winner_count,
  output logic                              tie
);

  localparam int scan_width   = calc_idx_width(num_counters + 1);
  localparam int settle_width = calc_idx_width(settle_cycles + 1);
  localparam logic [window_width-1:0] win_one    = {{(window_width-1){1'b0}}, 1'b1};
  localparam logic [settle_width-1:0] settle_one = {{(settle_width-1){1'b0}}, 1'b1};
  localparam logic [scan_width-1:0]   scan_one   = {{(scan_width-1){1'b0}}, 1'b1};
  localparam logic [settle_width-1:0] settle_init = settle_width'(settle_cycles - 1);
  localparam logic [scan_width-1:0]   scan_end    = scan_width'(num_counters);

  state_e                state_r, next_state_s;
  logic [window_width-1:0] win_r;
  logic [settle_width-1:0] settle_r;
  logic [scan_width-1:0]   scan_idx_r;
  logic [size_code-1:0]    snap_r [num_counters];
  logic [size_code-1:0]    cand_r, cand_s, max_r, step_val_s;
  logic [idx_width-1:0]    cand_idx_r, max_idx_r, step_idx_s;
  logic                    cand_vld_r, max_tie_r, step_tie_s;
  logic                    scan_last_s, settle_last_s, first_s;

  assign scan_last_s   = (scan_idx_r == scan_end);
  assign settle_last_s = (settle_r == {settle_width{1'b0}});
  assign first_s       = (cand_idx_r == {idx_width{1'b0}});

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:      next_state_s = start ? CLEAR : IDLE;
      CLEAR:     next_state_s = (win_r == {window_width{1'b0}}) ? SETTLE : INTEGRATE;
      INTEGRATE: next_state_s = (win_r == win_one) ? SETTLE : INTEGRATE;
      SETTLE:    next_state_s = settle_last_s ? SCAN : SETTLE;
      SCAN:      next_state_s = scan_last_s ? DONE : SCAN;
      DONE:      next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // Window down-counter and settle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_r    <= {window_width{1'b0}};
      settle_r <= {settle_width{1'b0}};
    end else begin
      if (state_r == IDLE && start) begin
        win_r <= window_len;
      end else if (state_r == INTEGRATE) begin
        win_r <= win_r - win_one;
      end else begin
        win_r <= win_r;
      end
      if (state_r != SETTLE) begin
        settle_r <= settle_init;
      end else if (!settle_last_s) begin
        settle_r <= settle_r - settle_one;
      end else begin
        settle_r <= settle_r;
      end
    end
  end

  // Count snapshot on the last settle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < num_counters; i++) snap_r[i] <= {size_code{1'b0}};
    end else if (state_r == SETTLE && settle_last_s) begin
      for (int i = 0; i < num_counters; i++) snap_r[i] <= counts[i*size_code +: size_code];
    end else begin
      for (int i = 0; i < num_counters; i++) snap_r[i] <= snap_r[i];
    end
  end

  // Snapshot read mux for the current scan index.
  always_comb begin
    cand_s = {size_code{1'b0}};
    for (int i = 0; i < num_counters; i++) begin
      cand_s = (scan_idx_r == scan_width'(i)) ? snap_r[i] : cand_s;
    end
  end

  // Scan index and candidate stage; the registered candidate keeps the wide
  // read mux out of the compare path, costing one extra scan cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx_r <= {scan_width{1'b0}};
      cand_r     <= {size_code{1'b0}};
      cand_idx_r <= {idx_width{1'b0}};
      cand_vld_r <= 1'b0;
    end else begin
      scan_idx_r <= (state_r == SCAN) ? scan_idx_r + scan_one : {scan_width{1'b0}};
      cand_r     <= cand_s;
      cand_idx_r <= idx_width'(scan_idx_r);
      cand_vld_r <= (state_r == SCAN) && !scan_last_s;
    end
  end

  argmax_step #(
    .size_code (size_code),
    .idx_width (idx_width)
  ) u_step (
    .first    (first_s),
    .cand_val (cand_r),
    .cand_idx (cand_idx_r),
    .max_val  (max_r),
    .max_idx  (max_idx_r),
    .max_tie  (max_tie_r),
    .new_val  (step_val_s),
    .new_idx  (step_idx_s),
    .new_tie  (step_tie_s)
  );

  // Running maximum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_r     <= {size_code{1'b0}};
      max_idx_r <= {idx_width{1'b0}};
      max_tie_r <= 1'b0;
    end else if (cand_vld_r) begin
      max_r     <= step_val_s;
      max_idx_r <= step_idx_s;
      max_tie_r <= step_tie_s;
    end else begin
      max_r     <= max_r;
      max_idx_r <= max_idx_r;
      max_tie_r <= max_tie_r;
    end
  end

  // Registered outputs: controls follow the next state, results load as the scan ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_clear_n  <= 1'b1;
      cnt_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner_idx   <= {idx_width{1'b0}};
      winner_count <= {size_code{1'b0}};
      tie          <= 1'b0;
    end else begin
      cnt_clear_n <= (next_state_s != CLEAR);
      cnt_enable  <= (next_state_s == INTEGRATE);
      busy        <= (next_state_s != IDLE);
      done        <= (next_state_s == DONE);
      if (state_r == SCAN && scan_last_s) begin
        winner_idx   <= step_idx_s;
        winner_count <= step_val_s;
        tie          <= step_tie_s;
      end else begin
        winner_idx   <= winner_idx;
        winner_count <= winner_count;
        tie          <= tie;
      end
    end
  end

endmodule
